// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared state encodings and defaults for the system-control block
package sys_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} reset_state_t;
  typedef enum logic {RUNNING, HALTED} halt_state_t;
  localparam logic [3:0] RESET_OPCODE_DEFAULT = 4'hE;
endpackage

// File: rtl/system_control_multi_if.sv
// system_control_multi_if: issue-side request/response and stall bundle of the system-control block
interface system_control_multi_if #(parameter int RESET_DOMAINS = 4, parameter int STALL_SOURCES = 4);
  logic                     clk_en;
  logic                     instruction_valid;
  logic [RESET_DOMAINS-1:0] baddr_in;
  logic [3:0]               minor_opcode_in;
  logic [4:0]               functional_unit_enable;
  logic [RESET_DOMAINS-1:0] reset_response_in;
  logic                     branch_stall_in;
  logic [STALL_SOURCES-1:0] stall_in;
  logic                     halt_req_in;
  logic                     resume_in;
  logic                     software_reset_out;
  logic [RESET_DOMAINS-1:0] reset_vector_out;
  logic [RESET_DOMAINS-1:0] reset_pending;
  logic                     reset_timeout;
  logic                     branch_stall_disable;
  logic                     halted;
  logic                     stall_en;
  modport master (
    output clk_en, instruction_valid, baddr_in, minor_opcode_in, functional_unit_enable,
           reset_response_in, branch_stall_in, stall_in, halt_req_in, resume_in,
    input  software_reset_out, reset_vector_out, reset_pending, reset_timeout,
           branch_stall_disable, halted, stall_en
  );
  modport slave (
    input  clk_en, instruction_valid, baddr_in, minor_opcode_in, functional_unit_enable,
           reset_response_in, branch_stall_in, stall_in, halt_req_in, resume_in,
    output software_reset_out, reset_vector_out, reset_pending, reset_timeout,
           branch_stall_disable, halted, stall_en
  );
endinterface

// File: rtl/sys_ctrl_reset_seq.sv
// sys_ctrl_reset_seq: software-reset sequencer with per-domain ack tracking
// Optional reset-wait timeout counter built when SYSCTRL_RESET_TIMEOUT_EN is defined.
module sys_ctrl_reset_seq
  import sys_ctrl_pkg::*;
#(
  parameter int RESET_DOMAINS = 4,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     clk_en,
  input  logic                     req,
  input  logic [RESET_DOMAINS-1:0] baddr_in,
  input  logic [RESET_DOMAINS-1:0] reset_response_in,
  output logic                     software_reset_out,
  output logic [RESET_DOMAINS-1:0] reset_vector_out,
  output logic [RESET_DOMAINS-1:0] reset_pending,
  output logic                     reset_timeout,
  output logic                     busy
);
  reset_state_t state_q, state_d;
  logic [RESET_DOMAINS-1:0] mask_q, mask_d, pending_q, pending_d, pending_nxt;
  logic tmo;
`ifdef SYSCTRL_RESET_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic timeout_q, timeout_d;
  assign cnt_inc = cnt_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  assign tmo = (state_q == WAIT) && (&cnt_inc);
  always_comb begin
    cnt_d = clk_en ? ((state_q == WAIT) ? cnt_inc : '0) : cnt_q;
    timeout_d = timeout_q | (clk_en & tmo);
  end
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  assign reset_timeout = timeout_q;
`else
  localparam int unused_timeout_width = TIMEOUT_WIDTH;
  assign tmo = 1'b0;
  assign reset_timeout = 1'b0;
`endif
  // The full-reset domain never acknowledges, so its pending bit is held at zero.
  assign pending_nxt = pending_q & ~reset_response_in;
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    pending_d = pending_q;
    if (clk_en && state_q == IDLE && req) begin
      state_d = ISSUE;
      mask_d = baddr_in;
      pending_d = {1'b0, baddr_in[RESET_DOMAINS-2:0]};
    end else if (clk_en && state_q != IDLE) begin
      state_d = (pending_nxt == '0 || tmo) ? IDLE : WAIT;
      mask_d = (state_d == IDLE) ? '0 : mask_q;
      pending_d = tmo ? '0 : pending_nxt;
    end
  end
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      state_q <= IDLE;
      mask_q <= '0;
      pending_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      pending_q <= pending_d;
    end
  assign software_reset_out = state_q == ISSUE;
  assign reset_vector_out = mask_q;
  assign reset_pending = pending_q;
  assign busy = state_q != IDLE;
endmodule

// File: rtl/system_control_multi.sv
// system_control_multi: software-reset decode/sequencing, halt/resume and pipeline stall merge
// Optional reset-wait timeout enabled by defining SYSCTRL_RESET_TIMEOUT_EN.
module system_control_multi
  import sys_ctrl_pkg::*;
#(
  parameter int          RESET_DOMAINS  = 4,
  parameter int          STALL_SOURCES  = 4,
  parameter logic [3:0]  RESET_OPCODE   = RESET_OPCODE_DEFAULT,
  parameter int          RESET_FU_INDEX = 2,
  parameter int          TIMEOUT_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  async_rst_n,
  system_control_multi_if.slave bus
);
  halt_state_t halt_q, halt_d;
  logic bsd_q, bsd_d, req, busy, unused_fu;
  logic [STALL_SOURCES-1:0] stall_src;
  assign unused_fu = ^bus.functional_unit_enable;
  assign req = bus.instruction_valid && bus.minor_opcode_in == RESET_OPCODE
               && bus.functional_unit_enable[RESET_FU_INDEX];
  sys_ctrl_reset_seq #(
    .RESET_DOMAINS(RESET_DOMAINS),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_seq (
    .clk               (clk),
    .async_rst_n       (async_rst_n),
    .clk_en            (bus.clk_en),
    .req               (req),
    .baddr_in          (bus.baddr_in),
    .reset_response_in (bus.reset_response_in),
    .software_reset_out(bus.software_reset_out),
    .reset_vector_out  (bus.reset_vector_out),
    .reset_pending     (bus.reset_pending),
    .reset_timeout     (bus.reset_timeout),
    .busy              (busy)
  );
  // Halt has priority over a simultaneous resume.
  always_comb begin
    halt_d = halt_q;
    bsd_d = bsd_q;
    if (bus.clk_en) begin
      halt_d = bus.halt_req_in ? HALTED : (bus.resume_in ? RUNNING : halt_q);
      bsd_d = bus.instruction_valid && bus.branch_stall_in;
    end
  end
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      halt_q <= RUNNING;
      bsd_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      bsd_q <= bsd_d;
    end
  assign stall_src = bus.stall_in;
  assign bus.halted = halt_q == HALTED;
  assign bus.branch_stall_disable = bsd_q;
  assign bus.stall_en = busy | bsd_q | (|stall_src) | bus.halt_req_in | bus.halted;
endmodule

// File: doc/system_control_multi.md
# system_control_multi

Parametrised processor system-control block: decodes the software-reset instruction, sequences a reset request across `RESET_DOMAINS` reset domains with per-domain acknowledge tracking and an optional timeout, and owns halt/resume. It merges branch, register, congestion, reset and halt stall sources into the single pipeline `stall_en`. It sits in ProcessorControl beside the issue stage.

## Interface
- `RESET_DOMAINS`, 4: width of the reset vector. Bit `RESET_DOMAINS-1` is the full reset; it is fire-and-forget and never awaits a response.
- `STALL_SOURCES`, 4: number of generic stall inputs OR-ed into `stall_en`.
- `RESET_OPCODE`, 4'hE: minor opcode that encodes the software reset.
- `RESET_FU_INDEX`, 2: bit of `functional_unit_enable` that qualifies the reset opcode.
- `TIMEOUT_WIDTH`, 8: width of the reset-wait timeout counter.
- `clk` input 1: the single clock.
- `async_rst_n` input 1: reset, asynchronous, active-low.
- `clk_en` input 1: global clock enable. All state updates are gated by it.
- `instruction_valid` input 1: the issue-stage instruction is valid.
- `baddr_in` input RESET_DOMAINS: requested reset-domain mask.
- `minor_opcode_in` input 4: minor opcode of the issuing instruction.
- `functional_unit_enable` input 5: one-hot functional unit select.
- `reset_response_in` input RESET_DOMAINS: per-domain reset-complete pulses.
- `branch_stall_in` input 1: branch stall request.
- `stall_in` input STALL_SOURCES: generic stall sources (register, congestion, …).
- `halt_req_in` input 1: halt request.
- `resume_in` input 1: resume request.
- `software_reset_out` output 1: single-cycle reset strobe.
- `reset_vector_out` output RESET_DOMAINS: active reset mask.
- `reset_pending` output RESET_DOMAINS: domains still awaiting a response.
- `reset_timeout` output 1: sticky timeout error flag.
- `branch_stall_disable` output 1: registered branch stall.
- `halted` output 1: the core is halted.
- `stall_en` output 1: pipeline stall.

## Operation
- **Reset request decode:** `req = instruction_valid && minor_opcode_in==RESET_OPCODE && functional_unit_enable[RESET_FU_INDEX]`.
- **Reset FSM states:** IDLE, ISSUE, WAIT.
  - IDLE → ISSUE on `req && clk_en`. This captures `baddr_in` into `mask` and loads `pending = baddr_in[RESET_DOMAINS-2:0]`.
  - ISSUE → WAIT if `pending` is nonzero after this cycle's responses; otherwise ISSUE → IDLE.
  - WAIT → IDLE when `pending` reaches 0, or on timeout.
  - A `req` outside IDLE is ignored.
- **Pending tracking:** `pending[i]` clears on `reset_response_in[i]` in ISSUE or WAIT.
  - A response for a non-pending domain is ignored.
  - A response arriving in the capture cycle itself is ignored.
- **Outputs per state:**
  - `software_reset_out` = 1 only in ISSUE.
  - `reset_vector_out` = `mask` in ISSUE and WAIT, 0 in IDLE.
  - `mask` is cleared on return to IDLE.
- **Halt FSM states:** RUNNING, HALTED.
  - RUNNING → HALTED on `halt_req_in && clk_en`.
  - HALTED → RUNNING on `resume_in && !halt_req_in && clk_en`. When both arrive together, halt wins.
  - A reset strobe does not clear HALTED.
  - `halted` = 1 in HALTED.
- **Branch stall:** `branch_stall_disable` is a register loaded with `instruction_valid && branch_stall_in` on each `clk_en`.
- **Stall merge:** `stall_en = (reset FSM != IDLE) | branch_stall_disable | (|stall_in) | halt_req_in | halted`. This output is combinational.

## Timing
- Asynchronous reset (`async_rst_n` = 0) sets:
  - all FSMs to IDLE/RUNNING;
  - `mask`, `pending`, timeout counter, `reset_timeout` and `branch_stall_disable` to 0.
  - Consequently every registered output is 0.
- Reset strobe latency: `software_reset_out` rises 1 `clk_en` cycle after `req` is sampled, and lasts exactly 1 `clk_en` cycle.
- `stall_en` behaviour:
  - It is not asserted combinationally by `req`.
  - It rises in the first cycle of ISSUE and falls in the cycle after `pending` clears.
- Minimum reset busy time: a mask containing only the full-reset bit gives 1 busy cycle.
- When `clk_en` = 0, all state holds and outputs are stable.
- Asserting `async_rst_n` mid-WAIT aborts the sequence immediately; no strobe is re-emitted.

## Configuration
- `SYSCTRL_RESET_TIMEOUT_EN` defined:
  - A counter increments on `clk_en` in WAIT and clears on entry to ISSUE.
  - When it reaches all-ones, the block sets `reset_timeout` (sticky until `async_rst_n`), clears `pending` and returns to IDLE.
- Not defined:
  - No counter is built; WAIT persists until all responses arrive.
  - `reset_timeout` is tied to 0.

## Structure
- Package `sys_ctrl_pkg`:
  - `reset_state_t` enum (IDLE, ISSUE, WAIT);
  - `halt_state_t` enum (RUNNING, HALTED);
  - `RESET_OPCODE_DEFAULT` = 4'hE.
- Sub-module `sys_ctrl_reset_seq` contains the reset FSM, mask/pending registers and timeout counter. The halt FSM, branch stall register and stall merge stay in the top level.

## Test plan
- **Reset with responses in order:** req with `baddr_in`=4'b0110 → strobe 1 cycle later with `reset_vector_out`=4'b0110. Pending goes 3'b110 → 3'b100 after resp[1] → 0 after resp[2]. `stall_en` drops the cycle after.
- **Full reset only:** `baddr_in`=4'b1000 → 1-cycle strobe, ISSUE → IDLE, `stall_en` high for exactly 1 cycle.
- **Spurious responses:** `reset_response_in`=4'b0001 while IDLE, and resp[0] on the capture cycle → no state change; pending[0] stays set.
- **Timeout:** with the macro, `TIMEOUT_WIDTH`=4 and no response → return to IDLE after 15 WAIT cycles, `reset_timeout`=1 held. Without the macro, the FSM stays in WAIT for 100 cycles.
- **Halt/resume:** `halt_req_in` and `resume_in` asserted together → HALTED. A later lone `resume_in` → RUNNING, `stall_en` deasserts.
- **clk_en and async reset:** `clk_en`=0 for 5 cycles mid-WAIT → pending and counter frozen. Then `async_rst_n` pulled low → all outputs 0 immediately.
